// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard/forwarding controller: shadow EXE/MEM/WB scoreboard, load-use stall, operand forward selects.
// Optional macro FORWARD_EN enables MEM/WB forwarding; without it, any in-flight producer in EXE/MEM stalls the consumer.
module exe_hazard_ctrl #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_valid,
  output logic             hazard,
  output logic [1:0]       sel_rn,
  output logic [1:0]       sel_rm,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } slot_t;

  slot_t exe_slot, mem_slot, wb_slot, id_slot;
  logic  exe_hit;
  logic  bubble;
  logic  unused_bits;

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = 1'b1;
    id_slot.dest     = id_dest;
    id_slot.wb_en    = id_wb_en;
    id_slot.mem_r_en = id_mem_r_en;
  end

  always_comb begin
    exe_hit = exe_slot.valid & exe_slot.wb_en &
              ((id_use1 & (id_src1 == exe_slot.dest)) |
               (id_use2 & (id_src2 == exe_slot.dest)));
  end

`ifdef FORWARD_EN
  logic [REG_W-1:0] exe_src1, exe_src2;
  logic             exe_use1, exe_use2;

  // MEM wins over WB; a load still in MEM has no data yet, so it is skipped.
  function automatic logic [1:0] fwd_sel(input slot_t e, input logic rd,
                                         input logic [REG_W-1:0] src,
                                         input slot_t m, input slot_t w);
    if (!(e.valid && rd))
      return 2'd0;
    if (m.valid && m.wb_en && !m.mem_r_en && (m.dest == src))
      return 2'd1;
    if (w.valid && w.wb_en && (w.dest == src))
      return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    hazard = id_valid & ~flush & exe_hit & exe_slot.mem_r_en;
    sel_rn = fwd_sel(exe_slot, exe_use1, exe_src1, mem_slot, wb_slot);
    sel_rm = fwd_sel(exe_slot, exe_use2, exe_src2, mem_slot, wb_slot);
  end
`else
  logic mem_hit;

  always_comb begin
    mem_hit = mem_slot.valid & mem_slot.wb_en &
              ((id_use1 & (id_src1 == mem_slot.dest)) |
               (id_use2 & (id_src2 == mem_slot.dest)));
    hazard  = id_valid & ~flush & (exe_hit | mem_hit);
    sel_rn  = '0;
    sel_rm  = '0;
  end
`endif

  assign bubble      = flush | hazard | ~id_valid;
  assign unused_bits = ^{wb_slot, mem_slot.mem_r_en};

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_slot  <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      stall_cnt <= '0;
`ifdef FORWARD_EN
      exe_src1  <= '0;
      exe_src2  <= '0;
      exe_use1  <= 1'b0;
      exe_use2  <= 1'b0;
`endif
    end else if (!freeze) begin
      wb_slot  <= mem_slot;
      mem_slot <= exe_slot;
      exe_slot <= bubble ? '0 : id_slot;
`ifdef FORWARD_EN
      exe_src1 <= bubble ? '0 : id_src1;
      exe_src2 <= bubble ? '0 : id_src2;
      exe_use1 <= bubble ? 1'b0 : id_use1;
      exe_use2 <= bubble ? 1'b0 : id_use2;
`endif
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed pipeline scenarios plus random traffic against an instruction-history model.
module tb_exe_hazard_ctrl;
  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 16;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, freeze, flush;
  logic [REG_W-1:0] id_src1, id_src2, id_dest;
  logic             id_use1, id_use2, id_wb_en, id_mem_r_en, id_valid;
  logic             hazard;
  logic [1:0]       sel_rn, sel_rm;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_valid(id_valid),
    .hazard(hazard), .sel_rn(sel_rn), .sel_rm(sel_rm), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    bit v; bit [3:0] dest; bit wb; bit ld;
    bit [3:0] s1; bit [3:0] s2; bit u1; bit u2;
  } ins_t;

  // hist[0] is the instruction in EXE, hist[1] one older (MEM), hist[2] two older (WB)
  ins_t        hist[$];
  int unsigned cnt;
  int          tests = 0, fails = 0;
  logic        last_haz;
  logic [1:0]  last_rn, last_rm;

  function automatic bit writes(ins_t p, bit [3:0] r);
    return p.v && p.wb && (p.dest == r);
  endfunction

  function automatic bit model_hazard();
    int depth;
    if (!id_valid || flush) return 1'b0;
    depth = FWD ? 1 : 2;
    for (int d = 0; d < depth; d++) begin
      if (FWD && !hist[d].ld) continue;
      if ((id_use1 && writes(hist[d], id_src1)) || (id_use2 && writes(hist[d], id_src2)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_sel(bit rd, bit [3:0] src);
    if (!FWD || !hist[0].v || !rd) return 2'd0;
    if (writes(hist[1], src) && !hist[1].ld) return 2'd1;
    if (writes(hist[2], src)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
    cnt = 0;
  endtask

  // One cycle: compare outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit   h;
    ins_t n;
    @(negedge clk);
    h = model_hazard();
    last_haz = hazard; last_rn = sel_rn; last_rm = sel_rm;
    check("hazard", hazard, h);
    check("sel_rn", sel_rn, model_sel(hist[0].u1, hist[0].s1));
    check("sel_rm", sel_rm, model_sel(hist[0].u2, hist[0].s2));
    check("stall_cnt", stall_cnt, (cnt >= 65535) ? 65535 : cnt);
    if (rst) model_reset();
    else if (!freeze) begin
      if (h) cnt++;
      n = '0;
      if (!(flush || h || !id_valid)) begin
        n.v = 1'b1; n.dest = id_dest; n.wb = id_wb_en; n.ld = id_mem_r_en;
        n.s1 = id_src1; n.s2 = id_src2; n.u1 = id_use1; n.u2 = id_use2;
      end
      hist.push_front(n);
      void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [3:0] d, input bit wb, input bit ld,
                        input bit [3:0] s1, input bit u1, input bit [3:0] s2, input bit u2);
    id_valid = v; id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
    id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Holds the current ID instruction until the DUT stops stalling it (bounded).
  task automatic hold_until_issued(output int stalls);
    stalls = 0;
    step();
    for (int g = 0; g < 10 && last_haz === 1'b1; g++) begin
      stalls++;
      step();
    end
  endtask

  int          stalls;
  int unsigned c0;

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    step();
    check("reset_cnt", stall_cnt, 0);
    rst = 1'b0;
    idle(2);

    // ALU R1 then back-to-back reader of R1 as Rn
    set_id(1, 1, 1, 0, 0, 0, 0, 0); step();
    set_id(1, 7, 1, 0, 1, 1, 9, 0); hold_until_issued(stalls);
    check("alu_b2b_stalls", stalls, FWD ? 0 : 2);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("alu_b2b_sel_rn", last_rn, FWD ? 1 : 0);
    idle(3);

    // ALU R2, unrelated, reader of R2 as Rm
    set_id(1, 2, 1, 0, 0, 0, 0, 0); step();
    set_id(1, 8, 1, 0, 9, 1, 10, 1); step();
    set_id(1, 7, 1, 0, 11, 1, 2, 1); hold_until_issued(stalls);
    check("alu_gap_stalls", stalls, FWD ? 0 : 1);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("alu_gap_sel_rm", last_rm, FWD ? 2 : 0);
    idle(3);

    // LDR R3 then reader of R3 as Rn
    c0 = stall_cnt;
    set_id(1, 3, 1, 1, 13, 1, 0, 0); step();
    set_id(1, 7, 1, 0, 3, 1, 0, 0); hold_until_issued(stalls);
    check("ldr_use_stalls", stalls, FWD ? 1 : 2);
    check("ldr_use_cnt", stall_cnt - c0, FWD ? 1 : 2);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("ldr_use_sel_rn", last_rn, FWD ? 2 : 0);
    idle(3);

    // LDR R4, reader squashed by flush in the same cycle
    c0 = stall_cnt;
    set_id(1, 4, 1, 1, 0, 0, 0, 0); step();
    set_id(1, 7, 1, 0, 4, 1, 4, 1); flush = 1'b1; step();
    check("flush_hazard", last_haz, 0);
    flush = 1'b0;
    idle(3);
    check("flush_cnt", stall_cnt - c0, 0);

    // LDR R5, reader stalls while memory freezes for 3 cycles
    c0 = stall_cnt;
    set_id(1, 5, 1, 1, 0, 0, 0, 0); step();
    set_id(1, 7, 1, 0, 0, 0, 5, 1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step();
    freeze = 1'b0;
    hold_until_issued(stalls);
    check("freeze_stalls", stalls + 3, FWD ? 4 : 5);
    check("freeze_cnt", stall_cnt - c0, FWD ? 1 : 2);
    idle(3);

    // Random traffic over a small register window so dependencies are frequent
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
             4'($urandom_range(0, 3)), 1'($urandom));
      step();
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exe_hazard_ctrl.md
Name: exe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the ARM-style 5-stage pipeline's execute stage.
- Keeps a shadow scoreboard of the instructions in EXE, MEM and WB (destination, write-back enable, load flag). It drives operand-forwarding selects for the Val_Rn/Val_Rm muxes feeding the ALU, and raises a one-cycle stall on load-use hazards.
- Sits beside the ID/EXE pipeline registers. Consumes ID-stage source info, the memory freeze and the branch flush.

Parameters:
- REG_W, 4, register index width (16 architectural registers)
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  memory wait; holds all shadow state and outputs
- flush  in  1  branch taken in EXE; squashes the ID instruction entering EXE
- id_src1  in  REG_W  Rn index of the ID instruction
- id_src2  in  REG_W  Rm/Rd-for-store index of the ID instruction
- id_use1  in  1  ID instruction reads src1
- id_use2  in  1  ID instruction reads src2 (register operand or store)
- id_dest  in  REG_W  destination of the ID instruction
- id_wb_en  in  1  ID instruction writes a register
- id_mem_r_en  in  1  ID instruction is a load
- id_valid  in  1  ID holds a real instruction
- hazard  out  1  stall PC/IF/ID and insert a bubble into EXE
- sel_rn  out  2  Val_Rn source: 0 register file, 1 MEM-stage ALU_res, 2 WB value
- sel_rm  out  2  Val_Rm source, same encoding
- stall_cnt  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Interface decision: single clock clk; reset rst is synchronous and active-high.
- Shadow slots EXE, MEM and WB each hold {valid, dest, wb_en, mem_r_en}. The EXE slot also holds {src1, src2, use1, use2}.
- Reset (rst=1 at a clk edge):
  - all slots valid=0 with fields zeroed;
  - hazard=0, sel_rn=sel_rm=0, stall_cnt=0.
  - Reset overrides freeze and flush.
- Advance each edge when freeze=0: WB<=MEM, MEM<=EXE.
  - EXE<=bubble (valid=0) if flush=1, or hazard=1, or id_valid=0.
  - Otherwise EXE<=ID fields.
- freeze=1: every slot and stall_cnt hold. Outputs are recomputed from the held state, so they are unchanged.
- Hazard (combinational from ID inputs and the EXE slot):
  - hazard=1 iff EXE.valid & EXE.mem_r_en & EXE.wb_en & id_valid & ((id_use1 & id_src1==EXE.dest) | (id_use2 & id_src2==EXE.dest)).
  - flush=1 forces hazard=0, because the ID instruction is being squashed.
  - A load-use pair costs exactly 1 bubble cycle. The consumer then reaches EXE while the load is in WB.
- Forwarding (combinational from the EXE slot against MEM/WB), per operand k in {1,2}, applied only when EXE.valid & EXE.usek:
  - If MEM.valid & MEM.wb_en & !MEM.mem_r_en & MEM.dest==EXE.srck, sel=1.
  - Else if WB.valid & WB.wb_en & WB.dest==EXE.srck, sel=2.
  - Else sel=0.
  - MEM has priority over WB (younger producer wins).
  - sel_rn follows src1; sel_rm follows src2.
- A load in MEM is never forwarded. This case cannot arise after a correct stall.
- stall_cnt increments on each edge where hazard=1 and freeze=0, and saturates at all-ones.
- Latency: outputs are valid in the same cycle as the inputs and state they depend on. There are no registered outputs besides stall_cnt.
- Reset mid-stall: bubble and hazard clear on the next edge. No partial instruction survives.

Optional Feature:
- Macro: FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - sel_rn and sel_rm are tied to 0.
  - hazard=1 whenever an ID source matches the dest of any valid wb_en instruction in the EXE or MEM slot, load or not. The consumer stalls until the producer reaches WB, with the register file write-before-read covering WB.
  - flush still masks hazard.

Test Plan:
- ALU R1<=.. then ADD using R1 as Rn, back-to-back -> in the consumer's EXE cycle sel_rn=1, hazard=0 throughout.
- ALU R2 producer, one unrelated instruction, then consumer of R2 as Rm -> sel_rm=2.
- LDR R3, then consumer of R3 as Rn -> hazard=1 for exactly 1 cycle, stall_cnt=1; the next cycle sel_rn=2.
- LDR R4, consumer of R4 issued with flush=1 in the same cycle -> hazard=0, EXE slot bubble, stall_cnt=0.
- LDR R5 + consumer stall, with freeze=1 for 3 cycles asserted during the hazard cycle -> hazard held at 1 for 4 cycles total, stall_cnt increments only once.
- Without FORWARD_EN: ADD R6 then consumer of R6 -> hazard=1 for 2 cycles, sel_rn=sel_rm=0 always.
